// File: rtl/seg_disp_pkg.sv
// Shared definitions for the multiplexed seven-segment display blocks:
// blank pattern, hex glyph table, mode step actions and index-width helper.
package seg_disp_pkg;

    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low glyphs, bit order g..a (bit 6 = g, bit 0 = a)
    localparam logic [6:0] HEX_GLYPH [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30,
        7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03,
        7'h46, 7'h21, 7'h06, 7'h0E
    };

    typedef enum logic [1:0] {
        STEP_NONE,
        STEP_NEXT,
        STEP_PREV
    } step_e;

    // Index width that never collapses to zero bits for single-entry ranges
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/seg_mode_scan_hex_to_seg7.sv
// Combinational nibble to active-low seven-segment glyph lookup.
module hex_to_seg7
    import seg_disp_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = HEX_GLYPH[nibble];

endmodule

// File: rtl/seg_mode_scan.sv
// Multiplexed seven-segment driver with button-stepped mode selection.
// Optional feature macro: LEADING_ZERO_BLANK_EN (blanks leading zero digits).
module seg_mode_scan
    import seg_disp_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int MODES    = 2,
    parameter int SCAN_DIV = 50000
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          btn_next,
    input  logic                          btn_prev,
    input  logic [MODES*DIGITS*4-1:0]     mode_vals,
    output logic [clog2_min1(MODES)-1:0]  mode,
    output logic [6:0]                    seven,
    output logic [DIGITS-1:0]             AN
);

    localparam int MW     = clog2_min1(MODES);
    localparam int DW     = clog2_min1(DIGITS);
    localparam int CW     = clog2_min1(SCAN_DIV);
    localparam int WORD_W = DIGITS * 4;

    localparam logic [MW-1:0] MODE_LAST  = MW'(MODES - 1);
    localparam logic [DW-1:0] DIGIT_LAST = DW'(DIGITS - 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(SCAN_DIV - 1);

    logic          next_hist, prev_hist;
    logic          press_next, press_prev;
    step_e         step;
    logic [MW-1:0] mode_nxt;

    logic [CW-1:0] scan_cnt, scan_cnt_nxt;
    logic [DW-1:0] digit, digit_nxt;

    logic [WORD_W-1:0] cur_word;
    logic [3:0]        cur_nibble;
    logic [6:0]        glyph;
    logic              lead_blank;
    logic [DIGITS-1:0] an_nxt;

    assign press_next = btn_next & ~next_hist;
    assign press_prev = btn_prev & ~prev_hist;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            next_hist <= 1'b0;
            prev_hist <= 1'b0;
            mode      <= '0;
            scan_cnt  <= '0;
            digit     <= '0;
        end else begin
            next_hist <= btn_next;
            prev_hist <= btn_prev;
            mode      <= mode_nxt;
            scan_cnt  <= scan_cnt_nxt;
            digit     <= digit_nxt;
        end
    end

    // Simultaneous presses cancel; wrap in both directions
    always_comb begin
        step     = STEP_NONE;
        mode_nxt = mode;
        if (press_next && !press_prev) begin
            step = STEP_NEXT;
        end else if (press_prev && !press_next) begin
            step = STEP_PREV;
        end
        case (step)
            STEP_NEXT: mode_nxt = (mode == MODE_LAST) ? '0 : mode + MW'(1);
            STEP_PREV: mode_nxt = (mode == '0) ? MODE_LAST : mode - MW'(1);
            default:   mode_nxt = mode;
        endcase
    end

    always_comb begin
        scan_cnt_nxt = scan_cnt + CW'(1);
        digit_nxt    = digit;
        if (scan_cnt == CNT_LAST) begin
            scan_cnt_nxt = '0;
            digit_nxt    = (digit == DIGIT_LAST) ? '0 : digit + DW'(1);
        end
    end

    always_comb begin
        cur_word = '0;
        for (int m = 0; m < MODES; m++) begin
            if (mode == MW'(m)) begin
                cur_word = mode_vals[m*WORD_W +: WORD_W];
            end
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    // zero_from[k] is set when nibble k and every nibble above it are zero
    logic [DIGITS:0] zero_from;
    always_comb begin
        zero_from         = '0;
        zero_from[DIGITS] = 1'b1;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            zero_from[k] = zero_from[k+1] & (cur_word[k*4 +: 4] == 4'h0);
        end
        cur_nibble = '0;
        lead_blank = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (digit == DW'(k)) begin
                cur_nibble = cur_word[k*4 +: 4];
                lead_blank = (k != 0) && zero_from[k];
            end
        end
    end
`else
    always_comb begin
        cur_nibble = '0;
        lead_blank = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (digit == DW'(k)) begin
                cur_nibble = cur_word[k*4 +: 4];
            end
        end
    end
`endif

    hex_to_seg7 u_hex_to_seg7 (
        .nibble (cur_nibble),
        .seg    (glyph)
    );

    assign an_nxt = ~(DIGITS'(1) << digit);

    // Registered outputs blank asynchronously while reset is held
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            AN    <= '1;
            seven <= SEG_BLANK;
        end else begin
            AN    <= an_nxt;
            seven <= lead_blank ? SEG_BLANK : glyph;
        end
    end

endmodule

// File: tb/tb_seg_mode_scan.sv
// Self-checking bench for seg_mode_scan (DIGITS=4, MODES=2, SCAN_DIV=4).
module tb_seg_mode_scan;

    localparam int DIGITS   = 4;
    localparam int MODES    = 2;
    localparam int SCAN_DIV = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        btn_next = 1'b0;
    logic        btn_prev = 1'b0;
    logic [31:0] mode_vals = {16'h1234, 16'h0000};
    logic        mode;
    logic [6:0]  seven;
    logic [3:0]  AN;

    int errors = 0;
    int checks = 0;
    int edges  = 0;

    logic [6:0] ref_glyph [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };
    logic [3:0] ref_an [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};

    typedef struct {
        logic [15:0] word0;
        int          digit;
        logic [3:0]  exp_an;
        logic [6:0]  exp_seven;
    } vec_t;

    vec_t vecs [17];

    seg_mode_scan #(
        .DIGITS   (DIGITS),
        .MODES    (MODES),
        .SCAN_DIV (SCAN_DIV)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .btn_next  (btn_next),
        .btn_prev  (btn_prev),
        .mode_vals (mode_vals),
        .mode      (mode),
        .seven     (seven),
        .AN        (AN)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        edges++;
    endtask

    function automatic int shown_digit();
        return ((edges - 1) / SCAN_DIV) % DIGITS;
    endfunction

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic nxt, input logic prv);
        btn_next = nxt;
        btn_prev = prv;
        tick();
    endtask

    // Advance until the registered outputs show digit d (at least one edge)
    task automatic wait_digit(input int d);
        int n = 0;
        tick();
        while (shown_digit() != d && n < 40) begin
            tick();
            n++;
        end
        if (shown_digit() != d) begin
            checks++;
            errors++;
            $display("[TB] FAIL wait_digit: got %0d expected %0d", shown_digit(), d);
        end
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        edges   = 0;
    endtask

    initial begin
        logic [15:0] w;
        int d;

        vecs[0]  = '{16'h0000, 0, 4'b1110, 7'h40};
        vecs[1]  = '{16'h1234, 0, 4'b1110, 7'h19};
        vecs[2]  = '{16'h1234, 1, 4'b1101, 7'h30};
        vecs[3]  = '{16'h1234, 2, 4'b1011, 7'h24};
        vecs[4]  = '{16'h1234, 3, 4'b0111, 7'h79};
        vecs[5]  = '{16'h5678, 0, 4'b1110, 7'h00};
        vecs[6]  = '{16'h5678, 1, 4'b1101, 7'h78};
        vecs[7]  = '{16'h5678, 2, 4'b1011, 7'h02};
        vecs[8]  = '{16'h5678, 3, 4'b0111, 7'h12};
        vecs[9]  = '{16'h9ABC, 0, 4'b1110, 7'h46};
        vecs[10] = '{16'h9ABC, 1, 4'b1101, 7'h03};
        vecs[11] = '{16'h9ABC, 2, 4'b1011, 7'h08};
        vecs[12] = '{16'h9ABC, 3, 4'b0111, 7'h10};
        vecs[13] = '{16'hDEF0, 0, 4'b1110, 7'h40};
        vecs[14] = '{16'hDEF0, 1, 4'b1101, 7'h0E};
        vecs[15] = '{16'hDEF0, 2, 4'b1011, 7'h06};
        vecs[16] = '{16'hDEF0, 3, 4'b0111, 7'h21};

        // Reset state, held across a clock edge
        #2 reset_n = 1'b0;
        #1;
        checkOutput("reset_an", 8'(AN), 8'h0F);
        checkOutput("reset_seven", 8'(seven), 8'h7F);
        checkOutput("reset_mode", 8'(mode), 8'h00);
        tick();
        checkOutput("reset_hold_an", 8'(AN), 8'h0F);
        release_reset();
        checkOutput("pre_first_edge_an", 8'(AN), 8'h0F);

        // First edge after release and anode stepping
        tick();
        checkOutput("first_an", 8'(AN), 8'h0E);
        checkOutput("first_seven", 8'(seven), 8'h40);
        for (int i = 1; i <= 4; i++) begin
            repeat (SCAN_DIV) tick();
            checkOutput($sformatf("scan_an_%0d", i), 8'(AN), 8'(ref_an[i % 4]));
        end

        // Table-driven decode at mode 0
        for (int i = 0; i < 17; i++) begin
            mode_vals = {16'h1234, vecs[i].word0};
            wait_digit(vecs[i].digit);
            checkOutput($sformatf("vec%0d_an", i), 8'(AN), 8'(vecs[i].exp_an));
            checkOutput($sformatf("vec%0d_seven", i), 8'(seven), 8'(vecs[i].exp_seven));
            checkOutput($sformatf("vec%0d_mode", i), 8'(mode), 8'h00);
        end
        mode_vals = {16'h1234, 16'h0000};

        // Held level gives exactly one step
        btn_next = 1'b1;
        tick();
        checkOutput("hold_step_mode", 8'(mode), 8'h01);
        repeat (19) tick();
        checkOutput("hold_after_mode", 8'(mode), 8'h01);
        wait_digit(0);
        checkOutput("mode1_d0_seven", 8'(seven), 8'h19);
        wait_digit(3);
        checkOutput("mode1_d3_seven", 8'(seven), 8'h79);
        checkOutput("mode1_d3_an", 8'(AN), 8'h07);
        applyStimulus(1'b0, 1'b0);
        checkOutput("release_mode", 8'(mode), 8'h01);

        // Wrap in both directions
        applyStimulus(1'b1, 1'b0);
        checkOutput("next_wrap_mode", 8'(mode), 8'h00);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1);
        checkOutput("prev_wrap_mode", 8'(mode), 8'h01);
        applyStimulus(1'b0, 1'b0);

        // Simultaneous presses cancel
        applyStimulus(1'b1, 1'b1);
        checkOutput("both_mode", 8'(mode), 8'h01);
        applyStimulus(1'b0, 1'b0);
        checkOutput("both_release_mode", 8'(mode), 8'h01);

        // Mode change coinciding with digit advance
        applyStimulus(1'b1, 1'b0);
        checkOutput("to_mode0", 8'(mode), 8'h00);
        applyStimulus(1'b0, 1'b0);
        for (int n = 0; n < SCAN_DIV && (edges % SCAN_DIV) != SCAN_DIV - 1; n++) tick();
        btn_next = 1'b1;
        tick();
        checkOutput("coincide_mode", 8'(mode), 8'h01);
        tick();
        d = shown_digit();
        w = 16'h1234;
        checkOutput("coincide_an", 8'(AN), 8'(ref_an[d]));
        checkOutput("coincide_seven", 8'(seven), 8'(ref_glyph[w[d*4 +: 4]]));
        applyStimulus(1'b0, 1'b0);

        // Asynchronous reset mid-cycle
        #3 reset_n = 1'b0;
        #1;
        checkOutput("async_an", 8'(AN), 8'h0F);
        checkOutput("async_seven", 8'(seven), 8'h7F);
        checkOutput("async_mode", 8'(mode), 8'h00);
        release_reset();
        tick();
        checkOutput("rerelease_an", 8'(AN), 8'h0E);
        checkOutput("rerelease_seven", 8'(seven), 8'h40);
        checkOutput("rerelease_mode", 8'(mode), 8'h00);

        // Leading zero handling on word 0030
        mode_vals = {16'h1234, 16'h0030};
        wait_digit(3);
`ifdef LEADING_ZERO_BLANK_EN
        checkOutput("lz_d3_seven", 8'(seven), 8'h7F);
`else
        checkOutput("lz_d3_seven", 8'(seven), 8'h40);
`endif
        checkOutput("lz_d3_an", 8'(AN), 8'h07);
        wait_digit(0);
        checkOutput("lz_d0_seven", 8'(seven), 8'h40);
        wait_digit(1);
        checkOutput("lz_d1_seven", 8'(seven), 8'h30);
        wait_digit(2);
`ifdef LEADING_ZERO_BLANK_EN
        checkOutput("lz_d2_seven", 8'(seven), 8'h7F);
`else
        checkOutput("lz_d2_seven", 8'(seven), 8'h40);
`endif
        checkOutput("lz_d2_an", 8'(AN), 8'h0B);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
